gb_timer: RTL and testbench
===========================

# gb_timer

Game Boy timer unit (DIV/TIMA/TMA/TAC at 0xFF04–0xFF07) that schedules TIMA increments from a free-running system counter and sequences the overflow/reload/interrupt handshake. Sits on the CPU I/O bus next to the other memory-mapped peripherals. Driven by the system clock plus a T-cycle enable strobe. Raises a one-cycle timer interrupt request toward the interrupt controller.

## Interface
- `RELOAD_DELAY`, default 4: T-cycle ticks between TIMA overflow and the TMA reload.
- `clk_in` input 1: system clock.
- `rst_in` input 1: synchronous, active-low reset.
- `tick_in` input 1: T-cycle enable strobe, one `clk_in` cycle wide. Nominally 4.194304 MHz.
- `addr_in` input 2: register select. 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
- `wr_en_in` input 1: write strobe, one cycle per write.
- `wr_data_in` input 8: write data.
- `rd_data_out` output 8: combinational read of the selected register.
- `irq_out` output 1: timer interrupt request, one-cycle pulse.

## Operation
- `sys_cnt`: 16-bit counter, +1 on each `tick_in`, wraps 0xFFFF→0x0000. DIV reads `sys_cnt[15:8]`.
- TAC[1:0] selects the tap bit: 00→bit 9, 01→bit 3, 10→bit 5, 11→bit 7. TAC[2] enables the timer.
- Edge detection:
  - `tap = sys_cnt[sel] & TAC[2]`, registered every clk cycle.
  - A 1→0 transition of `tap` increments TIMA.
  - This also applies to transitions caused by a DIV write or a TAC write, not only by counting.
- Reads:
  - TAC reads as `{5'b11111, TAC[2:0]}`.
  - TIMA/TMA read their stored values.
  - During OVF_WAIT, TIMA reads 0x00.
- Writes:
  - DIV: any value clears `sys_cnt` to 0.
  - TIMA, TMA, TAC: store `wr_data_in`. TAC keeps bits [2:0] only.
- State machine, advancing on `tick_in` only:
  - RUN: a TIMA increment from 0xFF yields 0x00 and moves to OVF_WAIT with the delay count cleared.
  - OVF_WAIT: TIMA holds 0x00. After `RELOAD_DELAY` ticks, move to RELOAD.
  - RELOAD: TIMA ← TMA and `irq_out` = 1 for exactly that clk cycle. The following clk cycle returns to RUN.
- Boundary rules:
  - TIMA write during OVF_WAIT: the write is stored, the reload is cancelled, no IRQ, back to RUN.
  - TIMA write in the RELOAD cycle: ignored, TMA value wins.
  - TMA write in the RELOAD cycle: the new value is loaded into TIMA.
  - Falling edge during OVF_WAIT: increments TIMA from 0x00 normally. The state stays OVF_WAIT.
  - Simultaneous tick edge and TIMA write in RUN: the write wins, no increment.
  - Simultaneous DIV write and `tick_in`: `sys_cnt` becomes 0, not 1.

## Timing
- Reset (`rst_in`=0 at a clk edge):
  - `sys_cnt`=0, TIMA=0, TMA=0, TAC=0, `tap` register=0, state=RUN, `irq_out`=0.
  - Reset overrides all writes and ticks in the same cycle.
  - Reset mid-OVF_WAIT aborts the reload with no IRQ.
- Write latency:
  - A write is visible on `rd_data_out` the clk cycle after `wr_en_in`.
  - A write-induced falling edge increments TIMA 1 clk cycle after the write.
- `rd_data_out` is combinational from the registers and `addr_in`, with zero latency.
- TIMA increment lands 1 clk cycle after the `tick_in` that drops the tap bit.
- Overflow to IRQ: `RELOAD_DELAY` ticks after the tick that wrapped TIMA. `irq_out` asserts on the clk cycle TIMA shows the TMA value.
- `irq_out` never stays high 2 consecutive cycles.

## Test plan
- Reset then 256 ticks, TAC=0 -> DIV reads 0x01, TIMA 0x00, TAC reads 0xF8, `irq_out` never high.
- TAC=0x05 (bit 3), TIMA=0xFE, TMA=0x80, 32 ticks -> TIMA=0xFF after 16 ticks, 0x00 on next increment, then 4 ticks later TIMA=0x80 with one `irq_out` pulse.
- Same setup, write TIMA=0x10 during OVF_WAIT -> TIMA=0x10, no IRQ, no reload.
- TAC=0x05, `sys_cnt`=0x0008 (bit 3 high), write DIV -> TIMA +1 on the next cycle.
- TMA write 0x42 in the RELOAD cycle -> TIMA=0x42. TIMA write in the RELOAD cycle -> ignored.
- `rst_in`=0 during OVF_WAIT -> all registers 0, no `irq_out`, state RUN.

Source files
------------

// File: rtl/gb_timer.sv
// Game Boy timer block: DIV/TIMA/TMA/TAC registers, falling-edge driven TIMA
// scheduling and the overflow -> delayed TMA reload -> interrupt sequence.
module gb_timer #(
  parameter int RELOAD_DELAY = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       tick_in,
  input  logic [1:0] addr_in,
  input  logic       wr_en_in,
  input  logic [7:0] wr_data_in,
  output logic [7:0] rd_data_out,
  output logic       irq_out
);

  localparam int CNT_W = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RELOAD_DELAY - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    OVF_WAIT = 2'd1,
    RELOAD   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [15:0]      sys_cnt;
  logic [7:0]       tima, tima_nxt;
  logic [7:0]       tma;
  logic [2:0]       tac;
  logic [CNT_W-1:0] dly_cnt, dly_cnt_nxt;
  logic             tap_p0, tap_p1, tap_sel, fall;
  logic             wr_div, wr_tima, wr_tma, wr_tac;

  assign wr_div  = wr_en_in && (addr_in == 2'd0);
  assign wr_tima = wr_en_in && (addr_in == 2'd1);
  assign wr_tma  = wr_en_in && (addr_in == 2'd2);
  assign wr_tac  = wr_en_in && (addr_in == 2'd3);

  always_comb begin
    tap_sel = 1'b0;
    case (tac[1:0])
      2'b00: tap_sel = sys_cnt[9];
      2'b01: tap_sel = sys_cnt[3];
      2'b10: tap_sel = sys_cnt[5];
      2'b11: tap_sel = sys_cnt[7];
      default: tap_sel = 1'b0;
    endcase
  end

  // Stage 0: live tap; stage 1: tap registered one clk later. A 1->0 between
  // them is an increment event, whether it came from counting or a register write.
  assign tap_p0 = tap_sel & tac[2];
  assign fall   = tap_p1 & ~tap_p0;

  always_comb begin
    state_nxt   = state;
    dly_cnt_nxt = dly_cnt;
    tima_nxt    = tima;
    case (state)
      RUN: begin
        if (wr_tima) begin
          tima_nxt = wr_data_in;
        end else if (fall) begin
          tima_nxt = tima + 8'd1;
          if (tima == 8'hFF) begin
            state_nxt   = OVF_WAIT;
            dly_cnt_nxt = '0;
          end
        end
      end
      OVF_WAIT: begin
        if (wr_tima) begin
          tima_nxt  = wr_data_in;
          state_nxt = RUN;
        end else begin
          if (fall) tima_nxt = tima + 8'd1;
          if (tick_in) begin
            if (dly_cnt == DLY_LAST) begin
              state_nxt = RELOAD;
              tima_nxt  = tma;
            end else begin
              dly_cnt_nxt = dly_cnt + 1'b1;
            end
          end
        end
      end
      RELOAD: begin
        // TIMA already holds TMA here; only a TMA write can change it.
        state_nxt = RUN;
        if (wr_tma) tima_nxt = wr_data_in;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sys_cnt <= '0;
      tima    <= '0;
      tma     <= '0;
      tac     <= '0;
      tap_p1  <= 1'b0;
      state   <= RUN;
      dly_cnt <= '0;
    end else begin
      if (wr_div)       sys_cnt <= '0;
      else if (tick_in) sys_cnt <= sys_cnt + 16'd1;
      if (wr_tma) tma <= wr_data_in;
      if (wr_tac) tac <= wr_data_in[2:0];
      tap_p1  <= tap_p0;
      state   <= state_nxt;
      dly_cnt <= dly_cnt_nxt;
      tima    <= tima_nxt;
    end
  end

  assign irq_out = (state == RELOAD);

  always_comb begin
    rd_data_out = 8'h00;
    case (addr_in)
      2'd0: rd_data_out = sys_cnt[15:8];
      2'd1: rd_data_out = (state == OVF_WAIT) ? 8'h00 : tima;
      2'd2: rd_data_out = tma;
      2'd3: rd_data_out = {5'b11111, tac};
      default: rd_data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_gb_timer.sv
// Bench for gb_timer: directed scenarios plus a randomized run, all checked
// against a register-level behavioural model of the timer.
module tb_gb_timer;

  localparam int RELOAD_DELAY = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       tick_in = 1'b0;
  logic [1:0] addr_in = 2'd0;
  logic       wr_en_in = 1'b0;
  logic [7:0] wr_data_in = 8'h00;
  logic [7:0] rd_data_out;
  logic       irq_out;

  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;
  int irq_dbl = 0;
  bit irq_prev = 0;

  gb_timer #(.RELOAD_DELAY(RELOAD_DELAY)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in), .addr_in(addr_in),
    .wr_en_in(wr_en_in), .wr_data_in(wr_data_in),
    .rd_data_out(rd_data_out), .irq_out(irq_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: phase 0 = counting, 1 = waiting for reload, 2 = reload cycle.
  int m_cnt, m_tima, m_tma, m_tac, m_phase, m_ticks;
  bit m_tap;

  function automatic int tap_bit(input int tac);
    case (tac & 3)
      0: return 9;
      1: return 3;
      2: return 5;
      default: return 7;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input int a);
    case (a)
      0: return 8'((m_cnt >> 8) & 255);
      1: return (m_phase == 1) ? 8'h00 : 8'(m_tima);
      2: return 8'(m_tma);
      default: return 8'(8'hF8 | m_tac);
    endcase
  endfunction

  task automatic model_step(input bit r, input bit t, input bit we, input int a, input int d);
    bit tap_now, fall;
    int n_tima, n_phase, n_ticks;
    if (!r) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_phase = 0; m_ticks = 0; m_tap = 0;
      return;
    end
    tap_now = ((m_tac >> 2) & 1) != 0 && ((m_cnt >> tap_bit(m_tac)) & 1) != 0;
    fall = m_tap && !tap_now;
    n_tima = m_tima; n_phase = m_phase; n_ticks = m_ticks;
    if (m_phase == 2) begin
      n_phase = 0;
      if (we && a == 2) n_tima = d;
    end else if (we && a == 1) begin
      n_tima = d;
      n_phase = 0;
    end else begin
      if (fall) begin
        n_tima = (m_tima + 1) % 256;
        if (m_phase == 0 && m_tima == 255) begin
          n_phase = 1;
          n_ticks = 0;
        end
      end
      if (m_phase == 1 && t) begin
        n_ticks = m_ticks + 1;
        if (n_ticks == RELOAD_DELAY) begin
          n_phase = 2;
          n_tima = m_tma;
        end
      end
    end
    if (we && a == 0) m_cnt = 0;
    else if (t) m_cnt = (m_cnt + 1) % 65536;
    if (we && a == 2) m_tma = d;
    if (we && a == 3) m_tac = d & 7;
    m_tap = tap_now;
    m_tima = n_tima; m_phase = n_phase; m_ticks = n_ticks;
  endtask

  task automatic step(input bit r, input bit t, input bit we, input logic [1:0] a, input logic [7:0] d);
    rst_in = r; tick_in = t; wr_en_in = we; addr_in = a; wr_data_in = d;
    @(posedge clk_in);
    model_step(r, t, we, int'(a), int'(d));
    #1;
    rst_in = 1'b1; tick_in = 1'b0; wr_en_in = 1'b0;
    if (irq_out) irq_cnt++;
    if (irq_out && irq_prev) irq_dbl++;
    irq_prev = irq_out;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    addr_in = a;
    #1;
    v = rd_data_out;
  endtask

  task automatic tick_pair();
    step(1, 1, 0, 2'd0, 8'h00);
    step(1, 0, 0, 2'd0, 8'h00);
  endtask

  task automatic setup_ovf(input logic [7:0] tma_v);
    step(1, 0, 1, 2'd0, 8'h00);
    step(1, 0, 1, 2'd3, 8'h05);
    step(1, 0, 1, 2'd2, tma_v);
    step(1, 0, 1, 2'd1, 8'hFE);
    step(1, 0, 0, 2'd0, 8'h00);
    irq_cnt = 0; irq_dbl = 0;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    step(0, 1, 1, 2'd2, 8'h55);
    step(0, 1, 1, 2'd3, 8'h07);
    rd(2'd0, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_div: got %h expected 00", v); end
    rd(2'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tima: got %h expected 00", v); end
    rd(2'd2, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL reset_tma: got %h expected 00", v); end
    rd(2'd3, v); checks++;
    if (v !== 8'hF8) begin errors++; $display("FAIL reset_tac: got %h expected F8", v); end
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq_out); end
  endtask

  task automatic test_div_count();
    logic [7:0] v;
    irq_cnt = 0;
    for (int i = 0; i < 256; i++) step(1, 1, 0, 2'd0, 8'h00);
    rd(2'd0, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL div_256: got %h expected 01", v); end
    rd(2'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL div_tima: got %h expected 00", v); end
    rd(2'd3, v); checks++;
    if (v !== 8'hF8) begin errors++; $display("FAIL div_tac: got %h expected F8", v); end
    checks++;
    if (irq_cnt != 0) begin errors++; $display("FAIL div_irq: got %0d pulses expected 0", irq_cnt); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    setup_ovf(8'h80);
    for (int i = 1; i <= 36; i++) begin
      tick_pair();
      rd(2'd1, v); checks++;
      if (v !== m_read(1)) begin errors++; $display("FAIL ovf_model_tima[%0d]: got %h expected %h", i, v, m_read(1)); end
      if (i == 16) begin
        checks++;
        if (v !== 8'hFF) begin errors++; $display("FAIL ovf_tima_ff: got %h expected FF", v); end
      end
      if (i == 32) begin
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL ovf_tima_wrap: got %h expected 00", v); end
      end
    end
    checks++;
    if (v !== 8'h80) begin errors++; $display("FAIL ovf_reload: got %h expected 80", v); end
    checks++;
    if (irq_cnt != 1 || irq_dbl != 0) begin
      errors++; $display("FAIL ovf_irq: got %0d pulses (%0d double) expected 1 (0)", irq_cnt, irq_dbl);
    end
  endtask

  task automatic test_cancel();
    logic [7:0] v;
    setup_ovf(8'h80);
    for (int i = 0; i < 33; i++) tick_pair();
    rd(2'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL cancel_wait_read: got %h expected 00", v); end
    tick_pair();
    step(1, 0, 1, 2'd1, 8'h10);
    for (int i = 0; i < 6; i++) tick_pair();
    rd(2'd1, v); checks++;
    if (v !== 8'h10) begin errors++; $display("FAIL cancel_tima: got %h expected 10", v); end
    checks++;
    if (irq_cnt != 0) begin errors++; $display("FAIL cancel_irq: got %0d pulses expected 0", irq_cnt); end
  endtask

  task automatic test_div_edge();
    logic [7:0] v;
    step(1, 0, 1, 2'd3, 8'h05);
    step(1, 0, 1, 2'd0, 8'h00);
    step(1, 0, 1, 2'd1, 8'h20);
    for (int i = 0; i < 8; i++) tick_pair();
    step(1, 0, 1, 2'd0, 8'h00);
    rd(2'd1, v); checks++;
    if (v !== 8'h20) begin errors++; $display("FAIL divedge_before: got %h expected 20", v); end
    step(1, 0, 0, 2'd0, 8'h00);
    rd(2'd1, v); checks++;
    if (v !== 8'h21) begin errors++; $display("FAIL divedge_after: got %h expected 21", v); end
  endtask

  task automatic test_div_tick_collision();
    logic [7:0] v;
    step(1, 1, 1, 2'd0, 8'h00);
    for (int i = 0; i < 255; i++) step(1, 1, 0, 2'd0, 8'h00);
    rd(2'd0, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL divtick_255: got %h expected 00", v); end
    step(1, 1, 0, 2'd0, 8'h00);
    rd(2'd0, v); checks++;
    if (v !== 8'h01) begin errors++; $display("FAIL divtick_256: got %h expected 01", v); end
  endtask

  task automatic test_reload_writes();
    logic [7:0] v;
    setup_ovf(8'h80);
    for (int i = 0; i < 35; i++) tick_pair();
    step(1, 1, 0, 2'd0, 8'h00);
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL reload_irq: got %b expected 1", irq_out); end
    rd(2'd1, v); checks++;
    if (v !== 8'h80) begin errors++; $display("FAIL reload_tima: got %h expected 80", v); end
    step(1, 0, 1, 2'd2, 8'h42);
    rd(2'd1, v); checks++;
    if (v !== 8'h42) begin errors++; $display("FAIL reload_tma_wr: got %h expected 42", v); end
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL reload_irq_end: got %b expected 0", irq_out); end
    setup_ovf(8'h42);
    for (int i = 0; i < 35; i++) tick_pair();
    step(1, 1, 0, 2'd0, 8'h00);
    step(1, 0, 1, 2'd1, 8'h99);
    rd(2'd1, v); checks++;
    if (v !== 8'h42) begin errors++; $display("FAIL reload_tima_wr: got %h expected 42", v); end
  endtask

  task automatic test_reset_ovf();
    logic [7:0] v;
    setup_ovf(8'h80);
    for (int i = 0; i < 33; i++) tick_pair();
    step(0, 0, 0, 2'd0, 8'h00);
    rd(2'd1, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rstovf_tima: got %h expected 00", v); end
    rd(2'd2, v); checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rstovf_tma: got %h expected 00", v); end
    rd(2'd3, v); checks++;
    if (v !== 8'hF8) begin errors++; $display("FAIL rstovf_tac: got %h expected F8", v); end
    for (int i = 0; i < 10; i++) tick_pair();
    checks++;
    if (irq_cnt != 0) begin errors++; $display("FAIL rstovf_irq: got %0d pulses expected 0", irq_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] v;
    bit r, t, we;
    logic [1:0] a;
    logic [7:0] d;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) != 0);
      t  = $urandom_range(0, 1) != 0;
      we = ($urandom_range(0, 19) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      if (a == 2'd1 && $urandom_range(0, 1) != 0) d = 8'hFD;
      if (a == 2'd3) d = {5'b0, 1'b1, d[1:0]};
      step(r, t, we, a, d);
      checks++;
      if (irq_out !== (m_phase == 2)) begin
        errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq_out, m_phase == 2);
      end
      for (int k = 0; k < 4; k++) begin
        rd(2'(k), v); checks++;
        if (v !== m_read(k)) begin
          errors++; $display("FAIL rand_reg%0d[%0d]: got %h expected %h", k, i, v, m_read(k));
        end
      end
    end
    checks++;
    if (irq_dbl != 0) begin errors++; $display("FAIL rand_irq_double: got %0d expected 0", irq_dbl); end
  endtask

  initial begin
    test_reset();
    test_div_count();
    test_overflow();
    test_cancel();
    test_div_edge();
    test_div_tick_collision();
    test_reload_writes();
    test_reset_ovf();
    irq_dbl = 0;
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
